// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the iterative Booth multiply/accumulate unit.
package booth_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACC  = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Multiple of A selected by one Booth digit.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        NEG1 = 3'd2,
        POS2 = 3'd3,
        NEG2 = 3'd4
    } digit_e;

    // Extended operand width: two extra bits let unsigned operands use the signed path exactly.
    function automatic int xw_of(input int width);
        return width + 2;
    endfunction

    // Recode steps needed to consume all XW multiplier bits.
    function automatic int steps_of(input int width, input bit radix4);
        return radix4 ? xw_of(width) / 2 : xw_of(width);
    endfunction

endpackage

// File: rtl/booth_mac_unit_if.sv
// Start/done handshake and operand/result bus of the Booth multiply/accumulate unit.
interface booth_mac_unit_if #(
    parameter int WIDTH = 32
);
    logic             mult_start;
    logic             mult_signed;
    logic             mult_acc_en;
    logic [WIDTH-1:0] mult_a;
    logic [WIDTH-1:0] mult_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             mult_ready;
    logic             mult_done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output mult_start, mult_signed, mult_acc_en, mult_a, mult_b, acc_hi, acc_lo,
        input  mult_ready, mult_done, result_hi, result_lo
    );

    modport slave (
        input  mult_start, mult_signed, mult_acc_en, mult_a, mult_b, acc_hi, acc_lo,
        output mult_ready, mult_done, result_hi, result_lo
    );
endinterface

// File: rtl/booth_recode.sv
// Combinational Booth recoder: multiplier window in, signed multiple of A out.
module booth_recode
    import booth_pkg::*;
#(
    parameter int XW     = 34,
    parameter bit RADIX4 = 1'b1
) (
    input  logic [2:0]    win,       // {b[i+1], b[i], b[i-1]}; radix-2 uses only the low two bits
    input  logic [XW-1:0] a_ext,
    output logic [XW+1:0] multiple
);
    digit_e        sel;
    logic [XW+1:0] a_sx;

    assign a_sx = {{2{a_ext[XW-1]}}, a_ext};

    // Decode the window into a digit selection.
    always_comb begin
        sel = ZERO;
        if (RADIX4) begin
            case (win)
                3'b001, 3'b010: sel = POS1;
                3'b011:         sel = POS2;
                3'b100:         sel = NEG2;
                3'b101, 3'b110: sel = NEG1;
                default:        sel = ZERO;
            endcase
        end else begin
            case (win[1:0])
                2'b01:   sel = POS1;
                2'b10:   sel = NEG1;
                default: sel = ZERO;
            endcase
        end
    end

    // Form the selected multiple of A.
    always_comb begin
        multiple = '0;
        case (sel)
            POS1:    multiple = a_sx;
            NEG1:    multiple = -a_sx;
            POS2:    multiple = a_sx << 1;
            NEG2:    multiple = -(a_sx << 1);
            default: multiple = '0;
        endcase
    end
endmodule

// File: rtl/booth_mac_unit.sv
// Iterative Booth multiplier with optional 2*WIDTH accumulate and start/done handshake.
module booth_mac_unit
    import booth_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit RADIX4 = 1'b1
) (
    input logic            sysclk,
    input logic            sysrst_n,
    booth_mac_unit_if.slave bus
);
    localparam int XW    = xw_of(WIDTH);
    localparam int STEPS = steps_of(WIDTH, RADIX4);
    localparam int PW    = 2 * XW + 2;          // {partial-product accumulator, multiplier shift bits}
    localparam int CW    = $clog2(STEPS + 1);
    localparam int SH    = RADIX4 ? 2 : 1;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [XW-1:0]        a_q;
    logic [PW-1:0]        prod_q, prod_step;
    logic                 prev_q, prev_step;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 acc_en_q;
    logic [WIDTH-1:0]     res_hi_q, res_lo_q;
    logic                 done_q, ready, accept, last_step;
    logic [XW-1:0]        a_ext_in, b_ext_in;
    logic [2:0]           win;
    logic [XW+1:0]        multiple, sum;
    logic signed [PW-1:0] shift_in;

    // Ready stays low through the done cycle so a start coinciding with done is dropped.
    assign ready     = (state_q == IDLE) && !done_q;
    assign accept    = bus.mult_start && ready;
    assign last_step = (cnt_q == CW'(STEPS - 1));

    assign a_ext_in = {{2{bus.mult_signed & bus.mult_a[WIDTH-1]}}, bus.mult_a};
    assign b_ext_in = {{2{bus.mult_signed & bus.mult_b[WIDTH-1]}}, bus.mult_b};

    // The unconsumed multiplier bits sit at the bottom of prod_q and shift out as steps retire.
    assign win       = RADIX4 ? {prod_q[1:0], prev_q} : {1'b0, prod_q[0], prev_q};
    assign prev_step = RADIX4 ? prod_q[1] : prod_q[0];

    booth_recode #(.XW(XW), .RADIX4(RADIX4)) u_recode (
        .win      (win),
        .a_ext    (a_q),
        .multiple (multiple)
    );

    assign sum       = prod_q[PW-1:XW] + multiple;
    assign shift_in  = {sum, prod_q[XW-1:0]};
    assign prod_step = shift_in >>> SH;

    // State register.
    always_ff @(posedge sysclk) begin
        if (!sysrst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (last_step) state_d = acc_en_q ? ACC : FIN;
            ACC:     state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, recode steps, accumulate and result/done registers.
    always_ff @(posedge sysclk) begin
        if (!sysrst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            prod_q   <= '0;
            prev_q   <= 1'b0;
            acc_q    <= '0;
            acc_en_q <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    a_q      <= a_ext_in;
                    prod_q   <= {{(XW + 2){1'b0}}, b_ext_in};
                    prev_q   <= 1'b0;
                    acc_q    <= {bus.acc_hi, bus.acc_lo};
                    acc_en_q <= bus.mult_acc_en;
                    cnt_q    <= '0;
                end
                CALC: begin
                    prod_q <= prod_step;
                    prev_q <= prev_step;
                    cnt_q  <= cnt_q + CW'(1);
                end
                ACC: prod_q[2*WIDTH-1:0] <= prod_q[2*WIDTH-1:0] + acc_q;
                FIN: begin
                    res_hi_q <= prod_q[2*WIDTH-1:WIDTH];
                    res_lo_q <= prod_q[WIDTH-1:0];
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mult_ready = ready;
    assign bus.mult_done  = done_q;
    assign bus.result_hi  = res_hi_q;
    assign bus.result_lo  = res_lo_q;
endmodule

// File: tb/tb_booth_mac_unit.sv
// Scoreboard bench: a 32-bit radix-4 unit and an 8-bit radix-2 unit against an arithmetic reference.
module tb_booth_mac_unit;
    logic sysclk   = 1'b0;
    logic sysrst_n = 1'b0;
    always #5 sysclk = ~sysclk;

    booth_mac_unit_if #(.WIDTH(32)) b32 ();
    booth_mac_unit_if #(.WIDTH(8))  b8 ();

    booth_mac_unit #(.WIDTH(32), .RADIX4(1'b1)) u32 (.sysclk(sysclk), .sysrst_n(sysrst_n), .bus(b32));
    booth_mac_unit #(.WIDTH(8),  .RADIX4(1'b0)) u8  (.sysclk(sysclk), .sysrst_n(sysrst_n), .bus(b8));

    typedef struct {
        logic [63:0] res;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Reference: extend both operands to their true values, multiply, add, wrap to 2*w bits.
    function automatic logic [63:0] model(input int w, input bit sgn, input bit ae,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] acc);
        logic signed [127:0] ea, eb, p;
        ea = 128'(a);
        eb = 128'(b);
        if (sgn && a[w-1]) ea = ea - (128'sd1 << w);
        if (sgn && b[w-1]) eb = eb - (128'sd1 << w);
        p = ea * eb;
        if (ae) p = p + 128'(acc);
        p = p & ((128'sd1 << (2 * w)) - 128'sd1);
        return p[63:0];
    endfunction

    function automatic int lat_of(input int w, input bit r4, input bit ae);
        return (r4 ? (w + 2) / 2 : w + 2) + 1 + (ae ? 1 : 0);
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return m;
            3:       return 32'd1 << (w - 1);
            4:       return m >> 1;
            default: return $urandom() & m;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue32(input bit sgn, input bit ae, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] acc);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge sysclk);
        while (!b32.mult_ready && guard < 100) begin
            @(negedge sysclk);
            guard++;
        end
        if (!b32.mult_ready) begin
            check("ready_timeout32", 64'(b32.mult_ready), 64'd1);
            return;
        end
        b32.mult_start  = 1'b1;
        b32.mult_signed = sgn;
        b32.mult_acc_en = ae;
        b32.mult_a      = a;
        b32.mult_b      = b;
        {b32.acc_hi, b32.acc_lo} = acc;
        e.res       = model(32, sgn, ae, a, b, acc);
        e.start_cyc = cyc + 1;
        e.lat       = lat_of(32, 1'b1, ae);
        q32.push_back(e);
        @(negedge sysclk);
        b32.mult_start  = 1'b0;
        b32.mult_signed = 1'($urandom());
        b32.mult_acc_en = 1'($urandom());
        b32.mult_a      = $urandom();
        b32.mult_b      = $urandom();
        b32.acc_hi      = $urandom();
        b32.acc_lo      = $urandom();
    endtask

    task automatic issue8(input bit sgn, input bit ae, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] acc);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge sysclk);
        while (!b8.mult_ready && guard < 100) begin
            @(negedge sysclk);
            guard++;
        end
        if (!b8.mult_ready) begin
            check("ready_timeout8", 64'(b8.mult_ready), 64'd1);
            return;
        end
        b8.mult_start  = 1'b1;
        b8.mult_signed = sgn;
        b8.mult_acc_en = ae;
        b8.mult_a      = a;
        b8.mult_b      = b;
        {b8.acc_hi, b8.acc_lo} = acc;
        e.res       = model(8, sgn, ae, 32'(a), 32'(b), 64'(acc));
        e.start_cyc = cyc + 1;
        e.lat       = lat_of(8, 1'b0, ae);
        q8.push_back(e);
        @(negedge sysclk);
        b8.mult_start  = 1'b0;
        b8.mult_signed = 1'($urandom());
        b8.mult_acc_en = 1'($urandom());
        b8.mult_a      = 8'($urandom());
        b8.mult_b      = 8'($urandom());
        b8.acc_hi      = 8'($urandom());
        b8.acc_lo      = 8'($urandom());
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q32.size() != 0 || q8.size() != 0) && guard < 500) begin
            @(negedge sysclk);
            guard++;
        end
        if (q32.size() != 0 || q8.size() != 0)
            check("drain_timeout", 64'(q32.size() + q8.size()), 64'd0);
    endtask

    exp_t m32, m8;

    always @(negedge sysclk) begin
        if (b32.mult_done) begin
            if (q32.size() == 0) begin
                check("unexpected_done32", 64'(b32.mult_done), 64'd0);
            end else begin
                m32 = q32.pop_front();
                check("result32", {b32.result_hi, b32.result_lo}, m32.res);
                check("latency32", 64'(cyc - m32.start_cyc), 64'(m32.lat));
                check("ready_at_done32", 64'(b32.mult_ready), 64'd0);
            end
        end
    end

    always @(negedge sysclk) begin
        if (b8.mult_done) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 64'(b8.mult_done), 64'd0);
            end else begin
                m8 = q8.pop_front();
                check("result8", 64'({b8.result_hi, b8.result_lo}), m8.res);
                check("latency8", 64'(cyc - m8.start_cyc), 64'(m8.lat));
                check("ready_at_done8", 64'(b8.mult_ready), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {b32.mult_start, b32.mult_signed, b32.mult_acc_en} = 3'b000;
        {b32.mult_a, b32.mult_b, b32.acc_hi, b32.acc_lo}   = '0;
        {b8.mult_start, b8.mult_signed, b8.mult_acc_en}    = 3'b000;
        {b8.mult_a, b8.mult_b, b8.acc_hi, b8.acc_lo}       = '0;
        sysrst_n = 1'b0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check("rst_ready32", 64'(b32.mult_ready), 64'd1);
        check("rst_done32", 64'(b32.mult_done), 64'd0);
        check("rst_result32", {b32.result_hi, b32.result_lo}, 64'd0);
        check("rst_ready8", 64'(b8.mult_ready), 64'd1);
        check("rst_result8", 64'({b8.result_hi, b8.result_lo}), 64'd0);
        sysrst_n = 1'b1;

        issue32(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 64'd0);
        drain();
        check("t1_result", {b32.result_hi, b32.result_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        issue32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
        drain();
        check("t2_result", {b32.result_hi, b32.result_lo}, 64'hFFFF_FFFE_0000_0001);
        issue32(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'd0);
        drain();
        check("t3_result", {b32.result_hi, b32.result_lo}, 64'h4000_0000_0000_0000);
        issue32(1'b1, 1'b1, 32'd2, 32'd3, 64'h0000_0000_FFFF_FFFF);
        drain();
        check("t4_result", {b32.result_hi, b32.result_lo}, 64'h0000_0001_0000_0005);

        // Operand change plus a second start while busy: one result, from the original operands.
        issue32(1'b1, 1'b0, $urandom(), $urandom(), 64'd0);
        repeat (4) @(negedge sysclk);
        check("busy_ready32", 64'(b32.mult_ready), 64'd0);
        b32.mult_b     = $urandom();
        b32.mult_start = 1'b1;
        @(negedge sysclk);
        b32.mult_start = 1'b0;
        drain();
        repeat (40) @(negedge sysclk);

        // Reset during CALC aborts with no done and cleared results.
        issue32(1'b0, 1'b1, $urandom(), $urandom(), {$urandom(), $urandom()});
        repeat (4) @(negedge sysclk);
        sysrst_n = 1'b0;
        q32.delete();
        @(negedge sysclk);
        sysrst_n = 1'b1;
        check("abort_ready32", 64'(b32.mult_ready), 64'd1);
        check("abort_done32", 64'(b32.mult_done), 64'd0);
        check("abort_result32", {b32.result_hi, b32.result_lo}, 64'd0);
        repeat (30) @(negedge sysclk);
        issue32(1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        issue8(1'b1, 1'b0, 8'h80, 8'hFF, 16'd0);
        drain();
        check("t6_result8", 64'({b8.result_hi, b8.result_lo}), 64'h0080);

        fork
            begin
                for (int i = 0; i < 150; i++)
                    issue32(1'($urandom()), 1'($urandom()), pick(32), pick(32),
                            {pick(32), pick(32)});
            end
            begin
                for (int j = 0; j < 300; j++)
                    issue8(1'($urandom()), 1'($urandom()), 8'(pick(8)), 8'(pick(8)),
                           {8'(pick(8)), 8'(pick(8))});
            end
        join
        drain();
        repeat (5) @(negedge sysclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
